idct_pixel_buffer: RTL and testbench



---
 rtl/jpeg_pkg.sv | 13 +
 rtl/pixel_saturate.sv | 34 +++
 rtl/idct_pixel_buffer.sv | 173 +++++++++++++++++
 tb/tb_idct_pixel_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG viewer constants: block geometry, default level shift and the
// encoding of the pixel-buffer read FSM.
package jpeg_pkg;

  localparam int BLOCK_PIXELS     = 64;
  localparam int BLOCK_DIM        = 8;
  localparam int LEVEL_SHIFT_DFLT = 128;

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_FETCH  = 2'd1;
  localparam logic [1:0] RD_STREAM = 2'd2;

endpackage

// File: rtl/pixel_saturate.sv
// Combinational level shift and clamp of a signed IDCT sample to an unsigned
// pixel; shared by the luma and chroma paths.
module pixel_saturate
  import jpeg_pkg::*;
#(
  parameter int O_OUT_PRECISION = 8,
  parameter int PIX_WIDTH       = 8,
  parameter int LEVEL_SHIFT     = LEVEL_SHIFT_DFLT
) (
  input  logic signed [O_OUT_PRECISION:0] sample,
  output logic        [PIX_WIDTH-1:0]     pixel
);

  localparam int SW = O_OUT_PRECISION + 2;
  localparam logic signed [SW-1:0] SHIFT   = SW'(LEVEL_SHIFT);
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_WIDTH) - 1);

  // One extra bit of headroom so the shifted sum never wraps.
  function automatic logic [PIX_WIDTH-1:0] shift_clamp(
    input logic signed [O_OUT_PRECISION:0] x
  );
    logic signed [SW-1:0] s;
    s = SW'(x) + SHIFT;
    if (s[SW-1])
      shift_clamp = '0;
    else if (s > PIX_MAX)
      shift_clamp = '1;
    else
      shift_clamp = s[PIX_WIDTH-1:0];
  endfunction

  assign pixel = shift_clamp(sample);

endmodule

// File: rtl/idct_pixel_buffer.sv
// Level-shifts IDCT samples into a ping-pong 8x8 pixel buffer and streams full
// blocks out over valid/ready. `IDCT_PIXEL_BUFFER_TRANSPOSE_EN selects column-major readout.
module idct_pixel_buffer
  import jpeg_pkg::*;
#(
  parameter int O_OUT_PRECISION = 8,
  parameter int PIX_WIDTH       = 8,
  parameter int LEVEL_SHIFT     = LEVEL_SHIFT_DFLT
) (
  input  logic                           i_sysclk,
  input  logic                           i_arstn,
  input  logic                           i_en,
  input  logic signed [O_OUT_PRECISION:0] i_O,
  output logic                           o_in_ready,
  output logic                           o_ovf,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic        [PIX_WIDTH-1:0]    o_data,
  output logic                           o_last
);

  localparam int CNT_W = $clog2(BLOCK_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_PIXELS - 1);
  localparam logic [CNT_W-1:0] PEN_IDX  = CNT_W'(BLOCK_PIXELS - 2);

  logic [PIX_WIDTH-1:0] pix_p0;
  logic [PIX_WIDTH-1:0] pix_p1;
  logic                 vld_p1;
  logic                 accept;
  logic                 wr_done;
  logic                 hs;
  logic                 blk_done;
  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [1:0]           rd_state;
  logic                 rd_bank_sel;
  logic [CNT_W-1:0]     rd_idx;
  logic [CNT_W-1:0]     rd_addr;
  logic [PIX_WIDTH-1:0] ram_q;
  logic [PIX_WIDTH-1:0] mem [2*BLOCK_PIXELS];

  pixel_saturate #(
    .O_OUT_PRECISION (O_OUT_PRECISION),
    .PIX_WIDTH       (PIX_WIDTH),
    .LEVEL_SHIFT     (LEVEL_SHIFT)
  ) u_sat (
    .sample (i_O),
    .pixel  (pix_p0)
  );

  // Refuse a sample that would follow the block-closing write into a bank still being read.
  assign o_in_ready = !full[wr_bank] && !(vld_p1 && (wr_cnt == LAST_IDX) && full[!wr_bank]);
  assign accept     = i_en && o_in_ready;
  assign wr_done    = vld_p1 && (wr_cnt == LAST_IDX);
  assign hs         = o_valid && i_ready;
  assign blk_done   = hs && o_last;

  // ---- stage p0 -> p1: saturated pixel registered ----
  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      vld_p1 <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (i_en && !o_in_ready)
        o_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (accept)
      pix_p1 <= pix_p0;
  end

  // ---- stage p1 -> RAM: write side ----
  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (vld_p1) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_done)
        wr_bank <= !wr_bank;
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      full <= 2'b00;
    end else begin
      if (wr_done)
        full[wr_bank] <= 1'b1;
      if (blk_done)
        full[rd_bank] <= 1'b0;
    end
  end

  // Prefetch index: the pixel that will be presented after the next handshake.
  always_comb begin
    rd_bank_sel = rd_bank;
    rd_idx      = '0;
    case (rd_state)
      RD_FETCH: rd_idx = CNT_W'(1);
      RD_STREAM: begin
        if (blk_done)
          rd_bank_sel = !rd_bank;
        else if (hs)
          rd_idx = rd_cnt + CNT_W'(2);
        else
          rd_idx = rd_cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

`ifdef IDCT_PIXEL_BUFFER_TRANSPOSE_EN
  assign rd_addr = {rd_idx[2:0], rd_idx[5:3]};
`else
  assign rd_addr = rd_idx;
`endif

  always_ff @(posedge i_sysclk) begin
    if (vld_p1)
      mem[{wr_bank, wr_cnt}] <= pix_p1;
    ram_q <= mem[{rd_bank_sel, rd_addr}];
  end

  // ---- RAM -> output register: read FSM ----
  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full[rd_bank])
            rd_state <= RD_FETCH;
        end
        RD_FETCH: begin
          o_data   <= ram_q;
          o_valid  <= 1'b1;
          o_last   <= 1'b0;
          rd_cnt   <= '0;
          rd_state <= RD_STREAM;
        end
        RD_STREAM: begin
          if (hs) begin
            if (o_last) begin
              rd_bank  <= !rd_bank;
              rd_cnt   <= '0;
              o_valid  <= 1'b0;
              o_last   <= 1'b0;
              rd_state <= full[!rd_bank] ? RD_FETCH : RD_IDLE;
            end else begin
              o_data <= ram_q;
              rd_cnt <= rd_cnt + 1'b1;
              o_last <= (rd_cnt == PEN_IDX);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_pixel_buffer.sv
// Scoreboard bench for idct_pixel_buffer: directed strobes push expected
// pixels, a negedge monitor pops and compares on every output handshake.
module tb_idct_pixel_buffer;

  logic              clk;
  logic              arstn;
  logic              en;
  logic signed [8:0] samp;
  logic              in_ready;
  logic              ovf;
  logic              valid;
  logic              ready;
  logic [7:0]        data;
  logic              last;

  idct_pixel_buffer dut (
    .i_sysclk   (clk),
    .i_arstn    (arstn),
    .i_en       (en),
    .i_O        (samp),
    .o_in_ready (in_ready),
    .o_ovf      (ovf),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_data     (data),
    .o_last     (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_hs     = 0;

  logic [8:0] exp_q [$];
  logic [7:0] blk [64];
  int         nblk = 0;

  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: outputs are stable at the negedge; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (arstn) begin
      if (prev_stall) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_data", int'(data), int'(prev_data));
        chk("hold_last", int'(last), int'(prev_last));
      end
      if (valid && ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", int'(data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", int'(data), int'(e[7:0]));
          chk("pixel_last", int'(last), int'(e[8]));
        end
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One strobe; expected pixel is tracked only for samples that should land in a block.
  task automatic strobe(input int v, input int pix, input bit exp_rdy, input bit track);
    int idx;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    samp = v[8:0];
    en   = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    if (track) begin
      blk[nblk] = pix[7:0];
      nblk++;
      if (nblk == 64) begin
        for (int j = 0; j < 64; j++) begin
`ifdef IDCT_PIXEL_BUFFER_TRANSPOSE_EN
          idx = (j % 8) * 8 + j / 8;
`else
          idx = j;
`endif
          exp_q.push_back({(j == 63), blk[idx]});
        end
        nblk = 0;
      end
    end
  endtask

  task automatic drain(input bit bp);
    int n = 0;
    while ((exp_q.size() != 0 || valid) && n < 3000) begin
      @(posedge clk); #1;
      if (bp) ready = ~ready;
      n++;
    end
    if (n >= 3000) chk("drain_timeout", n, 0);
    else           chk("idle_after_drain", int'(valid), 0);
    ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int sat_in  [6] = '{-256, -129, -128, 127, 255, -1};
    int sat_out [6] = '{0, 0, 0, 255, 255, 127};
    int hs0;

    arstn = 1'b0;
    en    = 1'b0;
    samp  = '0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    arstn = 1'b1;
    @(posedge clk); #1;

    // Constant block of zeros, latency measured from the last strobe.
    for (int k = 0; k < 64; k++) strobe(0, 128, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("lat_e1_valid", int'(valid), 0);
    @(posedge clk); #1;
    chk("lat_e2_valid", int'(valid), 0);
    @(posedge clk); #1;
    chk("lat_e3_valid", int'(valid), 1);
    drain(1'b0);

    // Saturation corners followed by zero fill.
    for (int k = 0; k < 6; k++) strobe(sat_in[k], sat_out[k], 1'b1, 1'b1);
    for (int k = 6; k < 64; k++) strobe(0, 128, 1'b1, 1'b1);
    drain(1'b0);

    // Ramp under alternating backpressure.
    ready = 1'b0;
    for (int k = 0; k < 64; k++) strobe(k - 128, k, 1'b1, 1'b1);
    ready = 1'b1;
    drain(1'b1);

    // Two back-to-back ramps at full throughput.
    for (int k = 0; k < 128; k++) strobe((k % 64) - 100, (k % 64) + 28, 1'b1, 1'b1);
    drain(1'b0);

    // Fill both banks with the output stalled; strobes 129-130 are dropped.
    ready = 1'b0;
    for (int k = 0; k < 128; k++) strobe(k - 128, k, 1'b1, 1'b1);
    chk("full_in_ready", int'(in_ready), 0);
    strobe(7, 0, 1'b0, 1'b0);
    strobe(8, 0, 1'b0, 1'b0);
    chk("full_ovf", int'(ovf), 1);
    hs0 = n_hs;
    ready = 1'b1;
    drain(1'b0);
    chk("full_pixel_count", n_hs - hs0, 128);
    chk("ovf_sticky", int'(ovf), 1);

    // Reset mid-block: the partial block must vanish.
    for (int k = 0; k < 30; k++) strobe(50, 0, 1'b1, 1'b0);
    arstn = 1'b0;
    @(posedge clk); #1;
    chk("rst2_ovf", int'(ovf), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    arstn = 1'b1;
    @(posedge clk); #1;
    hs0 = n_hs;
    for (int k = 0; k < 64; k++) strobe(5, 133, 1'b1, 1'b1);
    drain(1'b0);
    chk("rst2_pixel_count", n_hs - hs0, 64);
    chk("rst2_ovf_end", int'(ovf), 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("final_valid", int'(valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
